gray_codec_pipe: RTL and testbench

GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

---
 rtl/gray_codec_pipe.sv | 135 +++++++++++++
 tb/tb_gray_codec_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe
//   Two-stage Gray/binary converter with valid/ready handshakes on both sides.
//   S1 captures the input word and its mode. S2 holds the converted word that is
//   presented downstream. A word accepted on a clock edge is visible on the
//   output after the following edge. The pipeline sustains one word per cycle.
//
//   Optional build macro GRAY_CODEC_CHECK_EN adds an adjacency checker. It flags
//   any mode-0 (Gray) input whose Hamming distance from the previous mode-0
//   input is not exactly one bit.
//
// Ports
//   clk        sole clock; all state changes on its rising edge
//   rst        asynchronous, active-high reset
//   in_valid   input word present
//   in_ready   block accepts an input word this cycle
//   in_data    input code word [WIDTH-1:0]
//   in_mode    0 = Gray-to-binary, 1 = binary-to-Gray
//   out_valid  output word present
//   out_ready  downstream accepts the output word this cycle
//   out_data   converted word [WIDTH-1:0]
//   out_mode   mode that out_data was converted with
//   err_adj    adjacency-error flag for out_data (always 0 without the checker)
module gray_codec_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_mode,
   output logic             err_adj
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_data;
   logic             s1_mode;
   logic             s2_load;
   logic             in_fire;
   logic [WIDTH-1:0] conv_data;

   // S2 takes the S1 word when S2 is empty or is being drained this cycle.
   // S1 can then refill in the same cycle, so there is no bubble.
   assign s2_load  = s1_valid & (~out_valid | out_ready);
   assign in_ready = ~rst & (~s1_valid | s2_load);
   assign in_fire  = in_valid & in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_mode  <= 1'b0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_data  <= in_data;
         s1_mode  <= in_mode;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   // It is written as a prefix reduction so that no bit depends on another bit
   // of the same vector.
   always_comb begin
      conv_data = '0;
      if (s1_mode) begin
         conv_data = s1_data ^ (s1_data >> 1);
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            conv_data[i] = ^(s1_data >> i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mode  <= 1'b0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_data  <= conv_data;
         out_mode  <= s1_mode;
      end else if (out_valid & out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef GRAY_CODEC_CHECK_EN
   logic [WIDTH-1:0] hist_data;
   logic             hist_valid;
   logic [WIDTH-1:0] diff;
   logic             one_bit;
   logic             s1_err;

   // Exactly one bit differs: diff is non-zero and a power of two.
   assign diff    = in_data ^ hist_data;
   assign one_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

   // Only accepted Gray-mode words update the history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_data  <= '0;
         hist_valid <= 1'b0;
      end else if (in_fire & ~in_mode) begin
         hist_data  <= in_data;
         hist_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_err <= 1'b0;
      end else if (in_fire) begin
         s1_err <= ~in_mode & hist_valid & ~one_bit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_adj <= 1'b0;
      end else if (s2_load) begin
         err_adj <= s1_err;
      end
   end
`else
   assign err_adj = 1'b0;
`endif

endmodule

// File: tb/tb_gray_codec_pipe.sv
module tb_gray_codec_pipe;

`ifdef GRAY_CODEC_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       in_mode = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_mode;
   logic       err_adj;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] got_gray[$];
   logic [7:0] got_bin[$];

   always #5 clk = ~clk;

   gray_codec_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_mode(out_mode), .err_adj(err_adj)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int idx;
      // reset state
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_mode", out_mode, 0);
      chk("rst_err_adj", err_adj, 0);

      // release reset
      @(negedge clk); rst = 1'b0; #1;
      chk("post_rst_in_ready", in_ready, 1);

      // gray C0 -> binary 80
      @(negedge clk); in_valid = 1; in_data = 8'hC0; in_mode = 0; out_ready = 1;
      @(negedge clk); in_valid = 0;
      chk("c0_lat_valid_low", out_valid, 0);
      @(negedge clk);
      chk("c0_out_valid", out_valid, 1);
      chk("c0_out_data", out_data, 8'h80);
      chk("c0_out_mode", out_mode, 0);
      chk("c0_err", err_adj, 0);
      @(negedge clk);
      chk("c0_drained", out_valid, 0);

      // binary 80, FF back-to-back -> C0, 80
      in_valid = 1; in_data = 8'h80; in_mode = 1;
      @(negedge clk); in_data = 8'hFF;
      @(negedge clk); in_valid = 0;
      chk("b80_valid", out_valid, 1);
      chk("b80_data", out_data, 8'hC0);
      chk("b80_mode", out_mode, 1);
      @(negedge clk);
      chk("bff_valid", out_valid, 1);
      chk("bff_data", out_data, 8'h80);
      @(negedge clk);
      chk("bff_drained", out_valid, 0);

      // backpressure: three words offered, two buffered
      out_ready = 0; in_valid = 1; in_data = 8'h12; in_mode = 1; #1;
      chk("bp_rdy_a", in_ready, 1);
      @(negedge clk); in_data = 8'h34; in_mode = 0; #1;
      chk("bp_rdy_b", in_ready, 1);
      @(negedge clk); in_data = 8'h56; in_mode = 1; #1;
      chk("bp_rdy_c_blocked", in_ready, 0);
      chk("bp_data_a0", out_data, 8'h1B);
      @(negedge clk); #1;
      chk("bp_rdy_c_still", in_ready, 0);
      chk("bp_valid_a", out_valid, 1);
      chk("bp_data_a1", out_data, 8'h1B);
      chk("bp_mode_a", out_mode, 1);
      @(negedge clk);
      chk("bp_data_a2", out_data, 8'h1B);
      out_ready = 1; #1;
      chk("bp_rdy_c_open", in_ready, 1);
      @(negedge clk); in_valid = 0;
      chk("bp_data_b", out_data, 8'h27);
      chk("bp_mode_b", out_mode, 0);
      chk("bp_err_b", err_adj, CHK);
      @(negedge clk);
      chk("bp_data_c", out_data, 8'h7D);
      chk("bp_mode_c", out_mode, 1);
      @(negedge clk);
      chk("bp_drained", out_valid, 0);

      // adjacency sequence after a fresh reset
      rst = 1; #2; rst = 0;
      @(negedge clk); in_valid = 1; in_mode = 0; in_data = 8'h00;
      @(negedge clk); in_data = 8'h01;
      @(negedge clk); in_data = 8'h03;
      chk("adj0_data", out_data, 8'h00);
      chk("adj0_err", err_adj, 0);
      @(negedge clk); in_data = 8'h00;
      chk("adj1_data", out_data, 8'h01);
      chk("adj1_err", err_adj, 0);
      @(negedge clk); in_valid = 0;
      chk("adj2_data", out_data, 8'h02);
      chk("adj2_err", err_adj, 0);
      @(negedge clk);
      chk("adj3_data", out_data, 8'h00);
      chk("adj3_err", err_adj, CHK);
      @(negedge clk);
      chk("adj_drained", out_valid, 0);

      // reset with both stages full
      out_ready = 0; in_valid = 1; in_mode = 1; in_data = 8'h11;
      @(negedge clk); in_data = 8'h22;
      @(negedge clk); in_valid = 0;
      chk("full_valid", out_valid, 1);
      #1 rst = 1; #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_data", out_data, 0);
      @(negedge clk); rst = 0; out_ready = 1;
      @(negedge clk);
      chk("post_rst_empty0", out_valid, 0);
      @(negedge clk);
      chk("post_rst_empty1", out_valid, 0);
      in_valid = 1; in_mode = 0; in_data = 8'h07;
      @(negedge clk); in_valid = 0;
      @(negedge clk);
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_data", out_data, 8'h05);
      chk("post_rst_mode", out_mode, 0);
      chk("post_rst_err", err_adj, 0);
      @(negedge clk);

      // round trip: 0..255 binary->gray, then gray->binary, random out_ready
      rst = 1; #2; rst = 0;
      idx = 0;
      for (int cyc = 0; cyc < 3000 && got_gray.size() < 256; cyc++) begin
         @(negedge clk);
         in_valid = (idx < 256); in_data = idx[7:0]; in_mode = 1;
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (out_valid && out_ready) begin
            got_gray.push_back(out_data);
            chk("rt1_mode", out_mode, 1);
            chk("rt1_err", err_adj, 0);
         end
         if (in_valid && in_ready) idx++;
      end
      chk("rt1_count", got_gray.size(), 256);
      for (int i = 0; i < got_gray.size(); i++) begin
         logic [7:0] b;
         b = i[7:0];
         chk("rt1_gray", got_gray[i], b ^ (b >> 1));
      end

      idx = 0;
      for (int cyc = 0; cyc < 3000 && got_bin.size() < 256; cyc++) begin
         @(negedge clk);
         in_valid = (idx < got_gray.size());
         in_data = (idx < got_gray.size()) ? got_gray[idx] : 8'h00;
         in_mode = 0;
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (out_valid && out_ready) begin
            got_bin.push_back(out_data);
            chk("rt2_mode", out_mode, 0);
            chk("rt2_err", err_adj, 0);
         end
         if (in_valid && in_ready) idx++;
      end
      chk("rt2_count", got_bin.size(), 256);
      for (int i = 0; i < got_bin.size(); i++) begin
         chk("rt2_bin", got_bin[i], i[7:0]);
      end

      @(negedge clk); in_valid = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
